// File: rtl/segway_pkg.sv
// rtl/segway_pkg.sv - shared types and constants for the A2D conversion sequencer
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        GAP  = 2'd2,
        READ = 2'd3
    } a2d_state_t;

    localparam logic [2:0] LFT_CH_DEF  = 3'd0;
    localparam logic [2:0] RGHT_CH_DEF = 3'd4;
    localparam logic [2:0] BATT_CH_DEF = 3'd5;

    // Conversion command word: channel select in bits [13:11], everything else zero.
    function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/spi_mnrch.sv
// rtl/spi_mnrch.sv - 16-bit SPI master, SCLK idles high, MOSI on fall, MISO on rise
module spi_mnrch #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    localparam int CW   = $clog2(SCLK_DIV);
    localparam int HALF = SCLK_DIV / 2;

    logic          active;
    logic          done_pend;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [14:0]   tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            done_pend <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            bit_cnt   <= 4'd0;
            tx        <= 15'd0;
            rd_data   <= 16'd0;
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            MOSI      <= 1'b0;
        end else begin
            done      <= done_pend;
            done_pend <= 1'b0;
            if (!active) begin
                // done_pend keeps SS_n high for at least one clk between frames
                if (wrt && !done_pend) begin
                    active  <= 1'b1;
                    SS_n    <= 1'b0;
                    cnt     <= '0;
                    bit_cnt <= 4'd0;
                    tx      <= cmd[14:0];
                    MOSI    <= cmd[15];
                end
            end else begin
                cnt <= (cnt == CW'(SCLK_DIV - 1)) ? '0 : cnt + 1'b1;
                if (cnt == '0) begin
                    SCLK <= 1'b0;
                    if (bit_cnt != 4'd0) begin
                        MOSI <= tx[14];
                        tx   <= {tx[13:0], 1'b0};
                    end
                end
                if (cnt == CW'(HALF)) begin
                    SCLK    <= 1'b1;
                    rd_data <= {rd_data[14:0], MISO};
                end
                if (cnt == CW'(SCLK_DIV - 1)) begin
                    if (bit_cnt == 4'd15) begin
                        active    <= 1'b0;
                        SS_n      <= 1'b1;
                        MOSI      <= 1'b0;
                        done_pend <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/a2d_sequencer.sv
// rtl/a2d_sequencer.sv - round-robin A2D conversion of left, right and battery channels
module a2d_sequencer
    import segway_pkg::*;
#(
    parameter int         SCLK_DIV = 32,
    parameter logic [2:0] LFT_CH   = LFT_CH_DEF,
    parameter logic [2:0] RGHT_CH  = RGHT_CH_DEF,
    parameter logic [2:0] BATT_CH  = BATT_CH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    a2d_state_t  state;
    logic [1:0]  ptr;
    logic [2:0]  cur_ch;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic [3:0]  rd_hi_unused;

    assign rd_hi_unused = rd_data[15:12];

    always_comb begin
        cur_ch = BATT_CH;
        case (ptr)
            2'd0:    cur_ch = LFT_CH;
            2'd1:    cur_ch = RGHT_CH;
            default: cur_ch = BATT_CH;
        endcase
    end

    spi_mnrch #(.SCLK_DIV(SCLK_DIV)) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            wrt       <= 1'b0;
            cmd       <= 16'h0000;
            cnv_cmplt <= 1'b0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            batt      <= 12'h000;
        end else begin
            wrt       <= 1'b0;
            cnv_cmplt <= 1'b0;
            case (state)
                IDLE: begin
                    // a request landing on the completion pulse is dropped, not deferred
                    if (nxt && !cnv_cmplt) begin
                        wrt   <= 1'b1;
                        cmd   <= a2d_cmd(cur_ch);
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (done) state <= GAP;
                end
                GAP: begin
                    wrt   <= 1'b1;
                    state <= READ;
                end
                READ: begin
                    if (done) begin
                        case (ptr)
                            2'd0:    lft_ld  <= rd_data[11:0];
                            2'd1:    rght_ld <= rd_data[11:0];
                            default: batt    <= rd_data[11:0];
                        endcase
                        ptr       <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
                        cnv_cmplt <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_sequencer.sv
// tb/tb_a2d_sequencer.sv - randomized self-checking bench with A2D slave and conversion model
module tb_a2d_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        MISO = 1'b0;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        cnv_cmplt, SS_n, SCLK, MOSI;

    a2d_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A2D slave: each frame returns the result for the channel named in the previous frame
    logic [11:0] adc [8];
    logic [15:0] mosi_sh = 16'h0;
    logic [15:0] miso_sh = 16'h0;
    logic [2:0]  last_ch = 3'd0;
    int          obs_ch[$];

    always @(negedge SS_n) begin
        miso_sh = {4'($urandom), adc[last_ch]};
        MISO    = miso_sh[15];
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0) begin
            mosi_sh = {mosi_sh[14:0], MOSI};
            miso_sh = {miso_sh[14:0], 1'b0};
            MISO    = miso_sh[15];
        end
    end

    always @(posedge SS_n) begin
        if (rst_n === 1'b1) begin
            last_ch = mosi_sh[13:11];
            obs_ch.push_back(int'(mosi_sh[13:11]));
        end
    end

    int          cmplt_cnt = 0;
    int          hold_viol = 0;
    logic [35:0] prev_regs = 36'h0;

    always @(negedge clk) begin
        if (rst_n && cnv_cmplt) cmplt_cnt++;
        if (rst_n && !cnv_cmplt && ({lft_ld, rght_ld, batt} !== prev_regs)) hold_viol++;
        prev_regs = {lft_ld, rght_ld, batt};
    end

    // Reference model: round-robin pointer and the three result registers
    int          chans[3] = '{0, 4, 5};
    int          m_ptr = 0;
    logic [11:0] m_ld[3] = '{12'h0, 12'h0, 12'h0};
    int          lat_ref = -1;

    task automatic check_regs(input string tag);
        check({tag, "_lft"},  32'(lft_ld),  32'(m_ld[0]));
        check({tag, "_rght"}, 32'(rght_ld), 32'(m_ld[1]));
        check({tag, "_batt"}, 32'(batt),    32'(m_ld[2]));
    endtask

    // mode: 0 plain, 1 extra nxt at 10/500 clk, 2 nxt coincident with cnv_cmplt
    task automatic do_conv(input int mode);
        int ch;
        int lat;
        int start;
        bit got;
        ch    = chans[m_ptr];
        start = cmplt_cnt;
        got   = 1'b0;
        lat   = 0;
        @(posedge clk);
        #1 nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            nxt = (mode == 1) && (i == 8 || i == 498);
            if (cnv_cmplt) begin
                got = 1'b1;
                lat = i + 2;
                if (mode == 2) nxt = 1'b1;
                break;
            end
        end
        @(negedge clk);
        nxt = 1'b0;
        check("cmplt_seen", 32'(got), 32'd1);
        m_ld[m_ptr] = adc[ch];
        m_ptr = (m_ptr + 1) % 3;
        check_regs($sformatf("conv_ch%0d", ch));
        check("frame_cnt", 32'(obs_ch.size()), 32'd2);
        while (obs_ch.size() > 0) check($sformatf("frame_ch%0d", ch), 32'(obs_ch.pop_front()), 32'(ch));
        check("lat_max", 32'(lat <= 1096), 32'd1);
        if (lat_ref < 0) lat_ref = lat;
        else check("lat_const", 32'(lat), 32'(lat_ref));
        if (mode != 0) begin
            repeat (1200) @(negedge clk);
            check("single_cmplt", 32'(cmplt_cnt - start), 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) adc[i] = 12'h000;
        repeat (3) @(negedge clk);
        check("rst_ss_n", 32'(SS_n), 32'd1);
        check("rst_sclk", 32'(SCLK), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_cmplt", 32'(cnv_cmplt), 32'd0);
        check_regs("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        adc[0] = 12'h400;
        adc[4] = 12'h3C0;
        adc[5] = 12'hFFE;
        for (int k = 0; k < 3; k++) begin
            do_conv(0);
            repeat (160) @(negedge clk);
        end
        check("fixed_lft", 32'(lft_ld), 32'h400);
        check("fixed_rght", 32'(rght_ld), 32'h3C0);
        check("fixed_batt", 32'(batt), 32'hFFE);
        check("three_cmplt", 32'(cmplt_cnt), 32'd3);

        adc[0] = 12'h000;
        for (int k = 0; k < 3; k++) do_conv(0);

        do_conv(1);
        do_conv(2);

        // reset in the middle of the READ frame
        @(posedge clk);
        #1 nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
        repeat (800) @(negedge clk);
        check("pre_rst_ss_low", 32'(SS_n), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ss_n", 32'(SS_n), 32'd1);
        check("mid_rst_sclk", 32'(SCLK), 32'd1);
        check("mid_rst_mosi", 32'(MOSI), 32'd0);
        check("mid_rst_cmplt", 32'(cnv_cmplt), 32'd0);
        m_ptr = 0;
        m_ld  = '{12'h0, 12'h0, 12'h0};
        check_regs("mid_rst");
        obs_ch.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        adc[0] = 12'h5A5;
        do_conv(0);

        for (int k = 0; k < 9; k++) begin
            adc[0] = 12'($urandom);
            adc[4] = 12'($urandom);
            adc[5] = 12'($urandom);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            do_conv(0);
        end

        check("reg_hold", 32'(hold_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
